// File: rtl/ws2812_serializer.sv
// Pulls colour bytes from a trigger/data_request source and drives them MSB-first onto a WS2812 NRZ line,
// then holds the line low for the latch gap and reports frame completion or an aborted (underrun) frame.
module ws2812_serializer #(
  parameter int LEDS   = 32,
  parameter int T0H    = 4,
  parameter int T1H    = 9,
  parameter int TBIT   = 15,
  parameter int TRESET = 600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger,
  input  logic [7:0] data_in,
  output logic       data_request,
  output logic       ws_out,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int NBYTES = 3 * LEDS;
  localparam int BT_W   = (TBIT   > 1) ? $clog2(TBIT)   : 1;
  localparam int BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int RT_W   = (TRESET > 1) ? $clog2(TRESET) : 1;

  localparam logic [BT_W-1:0] TBIT_LAST = BT_W'(TBIT - 1);
  localparam logic [BT_W-1:0] T0H_C     = BT_W'(T0H);
  localparam logic [BT_W-1:0] T1H_C     = BT_W'(T1H);
  localparam logic [BC_W-1:0] BYTE_LAST = BC_W'(NBYTES - 1);
  localparam logic [RT_W-1:0] RST_LAST  = RT_W'(TRESET - 1);

  if (!(T0H > 0 && T0H < T1H && T1H < TBIT && TRESET > 0 && LEDS > 0)) begin : g_bad_timing
    $error("ws2812_serializer: timing parameters must satisfy 0 < T0H < T1H < TBIT, TRESET > 0, LEDS > 0");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [7:0]      r_shift;
  logic [2:0]      r_bit_cnt;
  logic [BT_W-1:0] r_bit_tmr;
  logic [BC_W-1:0] r_byte_cnt;
  logic [RT_W-1:0] r_rst_tmr;
  logic            r_complete;
  logic            r_ws;
  logic            r_frame_done;
  logic            r_underrun;

  logic            w_bit_end;
  logic            w_byte_end;
  logic            w_last_byte;
  logic            w_latch_end;
  logic            w_req;
  logic            w_underrun;
  logic            w_done;
  logic [BT_W-1:0] w_thresh;

  assign w_bit_end   = (r_bit_tmr == TBIT_LAST);
  assign w_byte_end  = w_bit_end && (r_bit_cnt == 3'd7);
  assign w_last_byte = (r_byte_cnt == BYTE_LAST);
  assign w_latch_end = (r_rst_tmr == RST_LAST);
  assign w_thresh    = r_shift[7] ? T1H_C : T0H_C;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_underrun  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (trigger) begin
          w_req       = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (w_byte_end) begin
          if (w_last_byte) begin
            w_state_nxt = S_LATCH;
          end else if (trigger) begin
            w_req = 1'b1;
          end else begin
            w_underrun  = 1'b1;
            w_state_nxt = S_LATCH;
          end
        end
      end
      S_LATCH: begin
        if (w_latch_end) begin
          w_state_nxt = S_IDLE;
          w_done      = r_complete;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control/timing registers: bit timer, bit/byte counters, latch timer, line and event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt    <= '0;
      r_bit_tmr    <= '0;
      r_byte_cnt   <= '0;
      r_rst_tmr    <= '0;
      r_complete   <= 1'b0;
      r_ws         <= 1'b0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_frame_done <= w_done;
      r_underrun   <= w_underrun;
      r_ws         <= (r_state == S_SEND) && (r_bit_tmr < w_thresh);
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_bit_cnt  <= '0;
            r_bit_tmr  <= '0;
            r_byte_cnt <= '0;
          end
        end
        S_SEND: begin
          if (!w_bit_end) begin
            r_bit_tmr <= r_bit_tmr + BT_W'(1);
          end else begin
            r_bit_tmr <= '0;
            if (r_bit_cnt != 3'd7) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end else if (w_req) begin
              r_bit_cnt  <= '0;
              r_byte_cnt <= r_byte_cnt + BC_W'(1);
            end else begin
              r_rst_tmr  <= '0;
              r_complete <= w_last_byte;
            end
          end
        end
        S_LATCH: begin
          if (!w_latch_end) r_rst_tmr <= r_rst_tmr + RT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Shift register: loaded on every consumed byte, shifted at each intra-byte bit boundary
  always_ff @(posedge clk) begin
    if (w_req) begin
      r_shift <= data_in;
    end else if ((r_state == S_SEND) && w_bit_end && (r_bit_cnt != 3'd7)) begin
      r_shift <= {r_shift[6:0], 1'b0};
    end
  end

  // The request is a same-cycle handshake; reset must never let a byte be consumed
  assign data_request = w_req && !rst;
  assign ws_out       = r_ws;
  assign busy         = (r_state != S_IDLE);
  assign frame_done   = r_frame_done;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_ws2812_serializer.sv
// Scoreboard bench for ws2812_serializer: the byte source pushes expected bits when a byte is consumed,
// a line monitor decodes ws_out pulses and pops/compares them.
`timescale 1ns/1ps
module tb_ws2812_serializer;

  localparam int LEDS   = 2;
  localparam int T0H    = 4;
  localparam int T1H    = 9;
  localparam int TBIT   = 15;
  localparam int TRESET = 600;
  localparam int NB     = 3 * LEDS;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       trigger = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_request;
  logic       ws_out;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  ws2812_serializer #(
    .LEDS(LEDS), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
  ) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .data_in(data_in),
    .data_request(data_request), .ws_out(ws_out), .busy(busy),
    .frame_done(frame_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_chk = 0;
  int         n_pass = 0;
  bit         q_bits[$];
  logic [7:0] src_q[$];
  bit         src_en = 1'b0;
  int         last_req = 0;
  int         frame_reqs = 0;
  int         n_done = 0;
  int         n_under = 0;
  int         n_req = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail_to(input string nm);
    n_chk++;
    $display("FAIL %s: timed out waiting for the event (cycle %0d)", nm, cyc);
  endtask

  // Byte source and event checker
  initial begin
    forever begin
      @(negedge clk);
      if (frame_done) begin
        n_done++;
        chk("done_busy_low", busy, 0);
        chk("done_gap", cyc - last_req, 8 * TBIT + TRESET + 1);
        chk("done_req_count", frame_reqs, NB);
        if (src_en && src_q.size() > 0) chk("done_next_req", data_request, 1);
      end
      if (underrun) begin
        n_under++;
        chk("under_gap", cyc - last_req, 8 * TBIT + 1);
        chk("under_busy", busy, 1);
      end
      if (data_request) begin
        if (busy) begin
          chk("req_spacing", cyc - last_req, 8 * TBIT);
          frame_reqs++;
        end else begin
          frame_reqs = 1;
        end
        last_req = cyc;
        n_req++;
        for (int b = 7; b >= 0; b--) q_bits.push_back(data_in[b]);
        if (src_q.size() > 0) void'(src_q.pop_front());
      end
      @(posedge clk);
      #1;
      trigger = src_en && (src_q.size() > 0);
      data_in = (src_q.size() > 0) ? src_q[0] : 8'h00;
    end
  end

  // Line monitor: decodes pulse widths and bit periods
  bit prev_ws = 1'b0;
  int hi_len = 0;
  int last_rise = -1;
  bit exp_bit;
  always @(negedge clk) begin
    if (rst) begin
      q_bits.delete();
      prev_ws   = 1'b0;
      hi_len    = 0;
      last_rise = -1;
    end else begin
      if (ws_out) begin
        if (!prev_ws) begin
          if (last_rise >= 0 && (cyc - last_rise) < 2 * TBIT)
            chk("bit_period", cyc - last_rise, TBIT);
          last_rise = cyc;
          hi_len    = 0;
        end
        hi_len++;
      end else if (prev_ws) begin
        if (q_bits.size() == 0) begin
          chk("unexpected_pulse_len", hi_len, 0);
        end else begin
          exp_bit = q_bits.pop_front();
          chk(exp_bit ? "high_len_one" : "high_len_zero", hi_len, exp_bit ? T1H : T0H);
        end
      end
      prev_ws = ws_out;
    end
  end

  task automatic wait_done(input int target, input int bound, input string nm);
    int t = 0;
    while (n_done < target && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (n_done < target) fail_to(nm);
  endtask

  logic [7:0] f_a[6] = '{8'hFF, 8'h00, 8'hA5, 8'h5A, 8'h80, 8'h01};
  logic [7:0] f_b[6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
  logic [7:0] f_c[6] = '{8'hC3, 8'h3C, 8'hE7, 8'h18, 8'h0F, 8'hF0};
  logic [7:0] f_d[6] = '{8'h55, 8'hAA, 8'h81, 8'h7E, 8'hFE, 8'h7F};

  initial begin
    int t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ws_out", ws_out, 0);
    chk("reset_request", data_request, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_underrun", underrun, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Two back-to-back frames with trigger held: the second starts in the frame_done cycle
    foreach (f_a[i]) src_q.push_back(f_a[i]);
    foreach (f_b[i]) src_q.push_back(f_b[i]);
    src_en = 1'b1;
    wait_done(2, 4000, "two_frames");
    chk("frames_req_total", n_req, 2 * NB);
    chk("frames_no_underrun", n_under, 0);

    // Source runs dry after two bytes of a frame
    @(posedge clk);
    #2;
    src_q.push_back(8'hC3);
    src_q.push_back(8'h3C);
    t = 0;
    while (n_under < 1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (n_under < 1) fail_to("underrun_pulse");
    t = 0;
    while (busy && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (busy) fail_to("underrun_latch_end");
    else chk("underrun_latch_len", cyc - last_req, 8 * TBIT + TRESET + 1);
    @(negedge clk);
    chk("underrun_no_done", n_done, 2);

    // Next frame must restart at byte 0 and complete normally
    @(posedge clk);
    #2;
    foreach (f_c[i]) src_q.push_back(f_c[i]);
    wait_done(3, 2000, "frame_after_underrun");

    // Reset in the middle of a high phase of the third byte
    @(posedge clk);
    #2;
    foreach (f_d[i]) src_q.push_back(f_d[i]);
    t = 0;
    while (!(frame_reqs == 3 && ws_out && busy) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!(frame_reqs == 3 && ws_out)) fail_to("reach_byte3_high");
    @(posedge clk);
    #2;
    rst    = 1'b1;
    src_en = 1'b0;
    @(negedge clk);
    chk("rst_request_gated", data_request, 0);
    @(negedge clk);
    chk("rst_ws_out_low", ws_out, 0);
    chk("rst_busy_low", busy, 0);
    chk("rst_request_low", data_request, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    src_q.delete();
    foreach (f_a[i]) src_q.push_back(f_a[i]);
    src_en = 1'b1;
    wait_done(4, 2000, "frame_after_reset");

    repeat (5) @(negedge clk);
    chk("final_req_total", n_req, 2 * NB + 2 + NB + 3 + NB);
    chk("final_underruns", n_under, 1);
    chk("final_frames", n_done, 4);
    chk("final_bits_left", q_bits.size(), 0);
    chk("final_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
